// File: rtl/vga_timing_gen.sv
// VGA timing generator: free-running pixel/line counters with registered sync, blank and frame_start outputs.
// Decodes are taken from the next counter values, so every output lines up with hcount/vcount in the same cycle.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 800,
  parameter int H_FP       = 40,
  parameter int H_SYNC     = 128,
  parameter int H_BP       = 88,
  parameter int V_ACTIVE   = 600,
  parameter int V_FP       = 1,
  parameter int V_SYNC     = 4,
  parameter int V_BP       = 23,
  parameter bit H_SYNC_POL = 1'b1,
  parameter bit V_SYNC_POL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [10:0] vcount,
  output logic        vsync,
  output logic        vblnk,
  output logic [10:0] hcount,
  output logic        hsync,
  output logic        hblnk,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL > 2047 || V_TOTAL > 2047) begin : g_total_check
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 2047");
    end
  endgenerate

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT      = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_ACT      = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic        h_wrap;
  logic        v_wrap;
  logic [10:0] h_next;
  logic [10:0] v_next;
  logic        hsync_next;
  logic        vsync_next;

  always_comb begin
    h_wrap = (hcount == H_LAST);
    v_wrap = (vcount == V_LAST);
    h_next = h_wrap ? 11'd0 : hcount + 11'd1;
    v_next = vcount;
    if (h_wrap) begin
      v_next = v_wrap ? 11'd0 : vcount + 11'd1;
    end
    hsync_next = (h_next >= H_SYNC_BEG && h_next < H_SYNC_END) ? H_SYNC_POL : ~H_SYNC_POL;
    vsync_next = (v_next >= V_SYNC_BEG && v_next < V_SYNC_END) ? V_SYNC_POL : ~V_SYNC_POL;
  end

  // frame_start is cleared on stalled edges so a pulse never outlives one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount      <= 11'd0;
      vcount      <= 11'd0;
      hblnk       <= 1'b0;
      vblnk       <= 1'b0;
      hsync       <= ~H_SYNC_POL;
      vsync       <= ~V_SYNC_POL;
      frame_start <= 1'b0;
    end else if (en) begin
      hcount      <= h_next;
      vcount      <= v_next;
      hblnk       <= (h_next >= H_ACT);
      vblnk       <= (v_next >= V_ACT);
      hsync       <= hsync_next;
      vsync       <= vsync_next;
      frame_start <= h_wrap && v_wrap;
    end else begin
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: dut_a uses the default 800x600 geometry for line-level checks,
// dut_b a 32x20 geometry so whole frames, stalls and mid-frame reset fit in a short run.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic        a_rst, a_en, a_hsync, a_hblnk, a_vsync, a_vblnk, a_fs;
  logic [10:0] a_hcount, a_vcount;
  logic        b_rst, b_en, b_hsync, b_hblnk, b_vsync, b_vblnk, b_fs;
  logic [10:0] b_hcount, b_vcount;

  vga_timing_gen dut_a (
    .clk(clk), .rst(a_rst), .en(a_en),
    .vcount(a_vcount), .vsync(a_vsync), .vblnk(a_vblnk),
    .hcount(a_hcount), .hsync(a_hsync), .hblnk(a_hblnk),
    .frame_start(a_fs)
  );

  // H: 16 active, sync 20..27, total 32.  V: 12 active, sync 13..16, total 20.
  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(12), .V_FP(1), .V_SYNC(4), .V_BP(3)
  ) dut_b (
    .clk(clk), .rst(b_rst), .en(b_en),
    .vcount(b_vcount), .vsync(b_vsync), .vblnk(b_vblnk),
    .hcount(b_hcount), .hsync(b_hsync), .hblnk(b_hblnk),
    .frame_start(b_fs)
  );

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int hi, vchg, bad, cnt, vblnk_rise_v, vs_cycles, vs_first, vs_last, fs_seen;
    int p1, p2, run, maxw;
    logic prev_vs, prev_vb, en_k;
    logic [25:0] snap;

    a_rst = 1'b1; a_en = 1'b0;
    b_rst = 1'b1; b_en = 1'b0;
    #1;
    tick(3);

    // ---- default geometry: reset and first line ----
    check("a_rst_hcount", int'(a_hcount), 0);
    check("a_rst_vcount", int'(a_vcount), 0);
    check("a_rst_hblnk", int'(a_hblnk), 0);
    check("a_rst_vblnk", int'(a_vblnk), 0);
    check("a_rst_hsync", int'(a_hsync), 0);
    check("a_rst_vsync", int'(a_vsync), 0);
    check("a_rst_fs", int'(a_fs), 0);

    a_rst = 1'b0; a_en = 1'b1;
    tick(799);
    check("a_h799", int'(a_hcount), 799);
    check("a_h799_hblnk", int'(a_hblnk), 0);
    tick(1);
    check("a_h800", int'(a_hcount), 800);
    check("a_h800_hblnk", int'(a_hblnk), 1);
    tick(39);
    check("a_h839_hsync", int'(a_hsync), 0);
    tick(1);
    check("a_h840", int'(a_hcount), 840);
    check("a_h840_hsync", int'(a_hsync), 1);
    hi = 1; vchg = 0;
    repeat (127) begin
      tick(1);
      if (a_hsync) hi++;
      if (a_vcount != 11'd0) vchg++;
    end
    check("a_h967", int'(a_hcount), 967);
    tick(1);
    check("a_h968", int'(a_hcount), 968);
    check("a_h968_hsync", int'(a_hsync), 0);
    check("a_hsync_width", hi, 128);
    check("a_hsync_vcount_moves", vchg, 0);
    tick(87);
    check("a_h1055", int'(a_hcount), 1055);
    check("a_h1055_vcount", int'(a_vcount), 0);
    tick(1);
    check("a_linewrap_h", int'(a_hcount), 0);
    check("a_linewrap_v", int'(a_vcount), 1);
    check("a_linewrap_hblnk", int'(a_hblnk), 0);
    check("a_linewrap_fs", int'(a_fs), 0);

    // ---- default geometry: reset mid-line ----
    tick(500);
    check("a_pre_rst_h", int'(a_hcount), 500);
    a_rst = 1'b1;
    tick(1);
    check("a_midrst_h", int'(a_hcount), 0);
    check("a_midrst_v", int'(a_vcount), 0);
    check("a_midrst_fs", int'(a_fs), 0);
    a_rst = 1'b0;
    tick(1);
    check("a_resume_h", int'(a_hcount), 1);
    check("a_resume_v", int'(a_vcount), 0);
    a_en = 1'b0;

    // ---- small geometry: full frame ----
    check("b_rst_hcount", int'(b_hcount), 0);
    check("b_rst_hsync", int'(b_hsync), 0);
    b_rst = 1'b0; b_en = 1'b1;
    tick(31);
    check("b_h31", int'(b_hcount), 31);
    tick(1);
    check("b_linewrap_h", int'(b_hcount), 0);
    check("b_linewrap_v", int'(b_vcount), 1);

    bad = 0; vblnk_rise_v = -1; vs_cycles = 0; vs_first = -1; vs_last = -1; fs_seen = 0;
    prev_vs = b_vsync; prev_vb = b_vblnk;
    repeat (607) begin
      tick(1);
      if ((b_vsync != prev_vs || b_vblnk != prev_vb) && b_hcount != 11'd0) bad++;
      if (b_vblnk && !prev_vb) vblnk_rise_v = int'(b_vcount);
      if (b_vsync) begin
        vs_cycles++;
        if (vs_first < 0) vs_first = int'(b_vcount);
        vs_last = int'(b_vcount);
      end
      if (b_fs) fs_seen++;
      prev_vs = b_vsync; prev_vb = b_vblnk;
    end
    check("b_vdecode_off_boundary", bad, 0);
    check("b_vblnk_rise_line", vblnk_rise_v, 12);
    check("b_vsync_cycles", vs_cycles, 128);
    check("b_vsync_first_line", vs_first, 13);
    check("b_vsync_last_line", vs_last, 16);
    check("b_no_early_fs", fs_seen, 0);
    check("b_last_h", int'(b_hcount), 31);
    check("b_last_v", int'(b_vcount), 19);
    tick(1);
    check("b_framewrap_h", int'(b_hcount), 0);
    check("b_framewrap_v", int'(b_vcount), 0);
    check("b_framewrap_fs", int'(b_fs), 1);
    check("b_framewrap_vblnk", int'(b_vblnk), 0);
    check("b_framewrap_vsync", int'(b_vsync), 0);
    tick(1);
    check("b_fs_width", int'(b_fs), 0);

    cnt = 1;
    while (cnt < 2000) begin
      tick(1);
      cnt++;
      if (b_fs) break;
    end
    check("b_frame_period", cnt, 640);
    tick(1);
    check("b_fs_width2", int'(b_fs), 0);

    // ---- small geometry: 50% enable ----
    bad = 0; p1 = -1; p2 = -1; run = 0; maxw = 0;
    for (int k = 0; k < 4000; k++) begin
      en_k = (k % 2 == 0);
      b_en = en_k;
      snap = {b_hcount, b_vcount, b_hsync, b_hblnk, b_vsync, b_vblnk};
      tick(1);
      if (!en_k && snap != {b_hcount, b_vcount, b_hsync, b_hblnk, b_vsync, b_vblnk}) bad++;
      run = b_fs ? run + 1 : 0;
      if (run > maxw) maxw = run;
      if (b_fs && !en_k) bad++;
      if (b_fs) begin
        if (p1 < 0) p1 = k;
        else if (p2 < 0) p2 = k;
      end
      if (p2 >= 0) break;
    end
    b_en = 1'b1;
    check("b_stall_hold", bad, 0);
    check("b_stall_fs_found", int'(p2 >= 0), 1);
    check("b_stall_period", p2 - p1, 1280);
    check("b_stall_fs_width", maxw, 1);

    // ---- small geometry: reset mid-frame ----
    cnt = 0;
    while (!(b_hcount == 11'd10 && b_vcount == 11'd7) && cnt < 1000) begin
      tick(1);
      cnt++;
    end
    check("b_reach_10_7", int'(b_hcount == 11'd10 && b_vcount == 11'd7), 1);
    b_rst = 1'b1;
    tick(1);
    check("b_midrst_h", int'(b_hcount), 0);
    check("b_midrst_v", int'(b_vcount), 0);
    check("b_midrst_fs", int'(b_fs), 0);
    check("b_midrst_vblnk", int'(b_vblnk), 0);
    b_rst = 1'b0;
    tick(1);
    check("b_resume_h", int'(b_hcount), 1);
    check("b_resume_v", int'(b_vcount), 0);
    check("b_resume_fs", int'(b_fs), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
